// File: rtl/pipe_stage_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: stage enables, fetch handshake, redirects.
// Optional performance counters are compiled in with `define PIPE_STAGE_CTRL_PERF_EN.
module pipe_stage_ctrl #(
  parameter int REG_W       = 5,
  parameter int BOOT_CYCLES = 2,
  parameter int PERF_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             iresp_data_ok,
  input  logic             dmem_req,
  input  logic             dresp_data_ok,
  input  logic             dec_valid,
  input  logic [REG_W-1:0] dec_rs,
  input  logic [REG_W-1:0] dec_rt,
  input  logic             dec_uses_rt,
  input  logic             ex_valid,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_redirect,
  output logic             ireq_valid,
  output logic             fetch_enable,
  output logic             decode_enable,
  output logic             decode_flush,
  output logic             execute_enable,
  output logic             execute_bubble,
  output logic             memory_enable,
  output logic             writeback_enable,
  output logic             pc_redirect,
  output logic [1:0]       fsm_state
`ifdef PIPE_STAGE_CTRL_PERF_EN
  ,
  output logic [PERF_W-1:0] stall_cycles,
  output logic [PERF_W-1:0] flush_count,
  output logic [PERF_W-1:0] load_use_count
`endif
);

  // Handshake: a fetch word is accepted on any cycle with ireq_valid & iresp_data_ok;
  // once raised, ireq_valid is never withdrawn before that acceptance.

  localparam int BW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    DWAIT = 2'd2
  } state_t;

  state_t        fsm;
  logic [BW-1:0] boot_cnt;
  logic          redir_pend;
  logic          ireq_out;
  logic          fetch_held;

  logic active;
  logic mem_wait;
  logic load_use;
  logic fetch_ok;
  logic fetch_avail;
  logic redir_set;
  logic lu_hit;

  assign fsm_state = fsm;

  assign active   = ~reset & (fsm != BOOT);
  assign mem_wait = dmem_req & ~dresp_data_ok;
  assign load_use = ex_valid & ex_mem_read & (ex_rd != '0) & dec_valid &
                    ((ex_rd == dec_rs) | (dec_uses_rt & (ex_rd == dec_rt)));

  // A word returned while the fetch register is frozen is kept here and
  // suppresses new requests until the fetch register consumes it.
  assign ireq_valid  = ~reset & ireq_out & ~fetch_held;
  assign fetch_ok    = ireq_valid & iresp_data_ok;
  assign fetch_avail = fetch_held | fetch_ok;

  always_comb begin
    fetch_enable     = 1'b0;
    decode_enable    = 1'b0;
    decode_flush     = 1'b0;
    execute_enable   = 1'b0;
    execute_bubble   = 1'b0;
    memory_enable    = 1'b0;
    writeback_enable = 1'b0;
    pc_redirect      = 1'b0;
    redir_set        = 1'b0;
    lu_hit           = 1'b0;
    if (active && !mem_wait) begin
      memory_enable    = 1'b1;
      writeback_enable = 1'b1;
      execute_enable   = 1'b1;
      if (redir_pend) begin
        // Execute already holds the bubble inserted when the redirect arrived.
        decode_enable = 1'b1;
        decode_flush  = 1'b1;
        if (fetch_avail) begin
          pc_redirect  = 1'b1;
          fetch_enable = 1'b1;
        end
      end else if (ex_redirect) begin
        decode_enable  = 1'b1;
        decode_flush   = 1'b1;
        execute_bubble = 1'b1;
        if (fetch_avail) begin
          pc_redirect  = 1'b1;
          fetch_enable = 1'b1;
        end else begin
          redir_set = 1'b1;
        end
      end else if (!fetch_avail) begin
        decode_enable = 1'b1;
        decode_flush  = 1'b1;
      end else if (load_use) begin
        execute_bubble = 1'b1;
        lu_hit         = 1'b1;
      end else begin
        fetch_enable  = 1'b1;
        decode_enable = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm        <= BOOT;
      boot_cnt   <= '0;
      redir_pend <= 1'b0;
      ireq_out   <= 1'b0;
      fetch_held <= 1'b0;
    end else begin
      case (fsm)
        BOOT: begin
          if (boot_cnt == BW'(BOOT_CYCLES - 1)) begin
            fsm      <= RUN;
            ireq_out <= 1'b1;
          end else begin
            boot_cnt <= boot_cnt + 1'b1;
          end
        end
        RUN, DWAIT: begin
          fsm        <= mem_wait ? DWAIT : RUN;
          fetch_held <= fetch_avail & ~fetch_enable;
          if (!mem_wait) begin
            if (redir_set)
              redir_pend <= 1'b1;
            else if (redir_pend && fetch_avail)
              redir_pend <= 1'b0;
          end
        end
        default: fsm <= BOOT;
      endcase
    end
  end

`ifdef PIPE_STAGE_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles   <= '0;
      flush_count    <= '0;
      load_use_count <= '0;
    end else begin
      if (active && !fetch_enable && stall_cycles != '1)
        stall_cycles <= stall_cycles + 1'b1;
      if (pc_redirect && flush_count != '1)
        flush_count <= flush_count + 1'b1;
      if (lu_hit && load_use_count != '1)
        load_use_count <= load_use_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_ctrl.sv
// Directed bench for pipe_stage_ctrl: each step drives one cycle of inputs,
// queues the expected output vector, and compares it mid-cycle.
module tb_pipe_stage_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       iresp_data_ok = 1'b0;
  logic       dmem_req = 1'b0;
  logic       dresp_data_ok = 1'b0;
  logic       dec_valid = 1'b0;
  logic [4:0] dec_rs = '0;
  logic [4:0] dec_rt = '0;
  logic       dec_uses_rt = 1'b0;
  logic       ex_valid = 1'b0;
  logic       ex_mem_read = 1'b0;
  logic [4:0] ex_rd = '0;
  logic       ex_redirect = 1'b0;
  logic       ireq_valid, fetch_enable, decode_enable, decode_flush;
  logic       execute_enable, execute_bubble, memory_enable, writeback_enable;
  logic       pc_redirect;
  logic [1:0] fsm_state;
`ifdef PIPE_STAGE_CTRL_PERF_EN
  logic [31:0] stall_cycles, flush_count, load_use_count;
`endif

  pipe_stage_ctrl #(.REG_W(5), .BOOT_CYCLES(2), .PERF_W(32)) dut (
    .clk(clk), .reset(reset), .iresp_data_ok(iresp_data_ok),
    .dmem_req(dmem_req), .dresp_data_ok(dresp_data_ok),
    .dec_valid(dec_valid), .dec_rs(dec_rs), .dec_rt(dec_rt),
    .dec_uses_rt(dec_uses_rt), .ex_valid(ex_valid), .ex_mem_read(ex_mem_read),
    .ex_rd(ex_rd), .ex_redirect(ex_redirect), .ireq_valid(ireq_valid),
    .fetch_enable(fetch_enable), .decode_enable(decode_enable),
    .decode_flush(decode_flush), .execute_enable(execute_enable),
    .execute_bubble(execute_bubble), .memory_enable(memory_enable),
    .writeback_enable(writeback_enable), .pc_redirect(pc_redirect),
    .fsm_state(fsm_state)
`ifdef PIPE_STAGE_CTRL_PERF_EN
    , .stall_cycles(stall_cycles), .flush_count(flush_count),
    .load_use_count(load_use_count)
`endif
  );

  // clock
  always #5 clk = ~clk;

  // {ireq, fetch_en, dec_en, dec_flush, ex_en, ex_bubble, mem_en, wb_en, pc_redirect}
  localparam logic [8:0] ZERO     = 9'b000000000;
  localparam logic [8:0] NORM     = 9'b111010110;
  localparam logic [8:0] HELD     = 9'b011010110;
  localparam logic [8:0] FREEZE   = 9'b100000000;
  localparam logic [8:0] LU       = 9'b100011110;
  localparam logic [8:0] FWAIT    = 9'b101110110;
  localparam logic [8:0] R_FULL   = 9'b111111111;
  localparam logic [8:0] R_PEND   = 9'b101111110;
  localparam logic [8:0] R_DONE   = 9'b111110111;

  wire [8:0] obs = {ireq_valid, fetch_enable, decode_enable, decode_flush,
                    execute_enable, execute_bubble, memory_enable,
                    writeback_enable, pc_redirect};

  logic [8:0] exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
    vectors++;
    assert (o === e) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  // driver: one cycle of stimulus, expectation queued then popped at mid-cycle
  task automatic step(input string tag, input logic rst, input logic ok,
                      input logic dreq, input logic dok, input logic dv,
                      input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                      input logic ev, input logic emr, input logic [4:0] rd,
                      input logic redir, input logic [8:0] exp_v);
    logic [8:0] e;
    @(posedge clk);
    #1;
    reset = rst; iresp_data_ok = ok; dmem_req = dreq; dresp_data_ok = dok;
    dec_valid = dv; dec_rs = rs; dec_rt = rt; dec_uses_rt = urt;
    ex_valid = ev; ex_mem_read = emr; ex_rd = rd; ex_redirect = redir;
    exp_q.push_back(exp_v);
    #3;
    e = exp_q.pop_front();
    check(tag, {23'd0, obs}, {23'd0, e});
  endtask

  initial begin
    // reset held 3 cycles, redirect/load inputs active to show gating
    step("rst0", 1, 1, 0, 0, 1, 5'd8, 0, 0, 1, 1, 5'd8, 1, ZERO);
    step("rst1", 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, ZERO);
    step("rst2", 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, ZERO);
    step("boot0", 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ZERO);
    step("boot1", 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, ZERO);
    step("run0", 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NORM);
    check("state_run", {30'd0, fsm_state}, 32'd1);
    // load-use on rs, then on rt, then ex_rd=0 and rt-unused cases
    step("lu_rs", 0, 1, 0, 0, 1, 5'd8, 5'd2, 0, 1, 1, 5'd8, 0, LU);
    step("lu_rs_after", 0, 1, 0, 0, 1, 5'd8, 5'd2, 0, 0, 0, 0, 0, HELD);
    step("lu_rd0", 0, 1, 0, 0, 1, 5'd0, 5'd0, 1, 1, 1, 5'd0, 0, NORM);
    step("lu_rt", 0, 1, 0, 0, 1, 5'd3, 5'd8, 1, 1, 1, 5'd8, 0, LU);
    step("lu_rt_after", 0, 1, 0, 0, 1, 5'd3, 5'd8, 1, 0, 0, 0, 0, HELD);
    step("lu_rt_unused", 0, 1, 0, 0, 1, 5'd3, 5'd8, 0, 1, 1, 5'd8, 0, NORM);
    // data-memory wait for 4 cycles, redirect ignored while frozen
    step("dw0", 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, FREEZE);
    step("dw1", 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, FREEZE);
    check("state_dwait", {30'd0, fsm_state}, 32'd2);
    step("dw2", 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, FREEZE);
    step("dw3", 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, FREEZE);
    step("dw_done", 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, NORM);
    // fetch returns during a freeze: held until the fetch register advances
    step("dw_fetch", 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, FREEZE);
    step("dw_held", 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, ZERO);
    step("dw_consume", 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, HELD);
    step("dw_resume", 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NORM);
    // redirect with fetch outstanding for 3 cycles
    step("rp_set", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, R_PEND);
    step("rp_wait1", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, FWAIT);
    step("rp_wait2", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, FWAIT);
    step("rp_done", 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, R_DONE);
    step("rp_once", 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NORM);
    // redirect beats load-use
    step("redir_lu", 0, 1, 0, 0, 1, 5'd8, 0, 0, 1, 1, 5'd8, 1, R_FULL);
    step("fwait", 0, 0, 0, 0, 1, 5'd1, 0, 0, 0, 0, 0, 0, FWAIT);
    step("fwait_done", 0, 1, 0, 0, 1, 5'd1, 0, 0, 0, 0, 0, 0, NORM);
    // pending redirect then freeze, then reset in DWAIT
    step("rr_set", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, R_PEND);
    step("rr_dw0", 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, FREEZE);
    step("rr_dw1", 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, FREEZE);
    check("state_rr_dwait", {30'd0, fsm_state}, 32'd2);
`ifdef PIPE_STAGE_CTRL_PERF_EN
    check("perf_stall", stall_cycles, 32'd14);
    check("perf_flush", flush_count, 32'd2);
    check("perf_lu", load_use_count, 32'd2);
`endif
    step("rr_reset", 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, ZERO);
    step("rr_boot0", 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ZERO);
    check("state_boot", {30'd0, fsm_state}, 32'd0);
`ifdef PIPE_STAGE_CTRL_PERF_EN
    check("perf_stall_clr", stall_cycles, 32'd0);
    check("perf_flush_clr", flush_count, 32'd0);
    check("perf_lu_clr", load_use_count, 32'd0);
`endif
    step("rr_boot1", 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ZERO);
    step("rr_run", 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NORM);
    step("rr_run2", 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NORM);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
